lock_attempt_ctrl: RTL and testbench
====================================

// Module: lock_attempt_ctrl
// PURPOSE
//   Downstream stage of the serial password detector. Consumes its one-cycle
//   result pulses (correct / incorrect). Drives the door-unlock level for a
//   fixed window and counts consecutive failures. After MAX_FAILS failures it
//   raises an alarm and enforces a timed lockout, during which the detector is
//   gated off via det_enable.
// PARAMETERS
//   MAX_FAILS       3     consecutive incorrect results that trigger lockout (>=1)
//   UNLOCK_CYCLES   256   cycles unlock stays high after a correct result (>=1)
//   LOCKOUT_CYCLES  1024  cycles of lockout after the final failure (>=1)
//   (local) FAIL_W = $clog2(MAX_FAILS+1); TMR_W = $clog2(max(UNLOCK,LOCKOUT)+1)
// PORTS
//   clk            in   1       clock, rising edge
//   rstn           in   1       reset, asynchronous, active-low
//   res_correct    in   1       1-cycle pulse: password accepted
//   res_incorrect  in   1       1-cycle pulse: password rejected
//   relock         in   1       level; forces early relock while UNLOCKED
//   det_enable     out  1       1 = detector may accept entries
//   unlock         out  1       door unlock level
//   locked_out     out  1       1 while in LOCKOUT
//   alarm          out  1       1-cycle pulse on lockout entry
//   fail_cnt       out  FAIL_W  current consecutive-failure count
// BEHAVIOUR
//   - All outputs are registered. Reset: state=ARMED, det_enable=1, unlock=0,
//     locked_out=0, alarm=0, fail_cnt=0, timer=0. Reset mid-operation aborts
//     any unlock or lockout window immediately (async).
//   - States: ARMED, UNLOCKED, LOCKOUT. Inputs are sampled on rising clk; the
//     response is visible the following cycle (1-cycle latency).
//   - ARMED: det_enable=1, unlock=0, locked_out=0.
//     * res_correct only -> UNLOCKED; fail_cnt<=0; timer<=UNLOCK_CYCLES-1.
//     * res_incorrect -> fail_cnt<=fail_cnt+1. If fail_cnt+1==MAX_FAILS:
//       -> LOCKOUT; timer<=LOCKOUT_CYCLES-1; alarm=1 for exactly one cycle.
//       Otherwise stay in ARMED.
//     * Both pulses in the same cycle are a protocol error. They are treated
//       as res_incorrect (fail-secure).
//   - UNLOCKED: unlock=1, det_enable=0. Result pulses are ignored and do not
//     change fail_cnt. The timer decrements each cycle.
//     At timer==0 or relock==1 -> ARMED.
//     unlock is therefore high for exactly UNLOCK_CYCLES cycles unless relocked.
//     relock takes priority over the timer. relock has no effect in other states.
//   - LOCKOUT: locked_out=1, det_enable=0, unlock=0. Result pulses are ignored.
//     The timer decrements. At timer==0 -> ARMED; fail_cnt<=0.
//     locked_out is high for exactly LOCKOUT_CYCLES cycles.
//   - fail_cnt saturates at MAX_FAILS and never wraps. It holds its value
//     through LOCKOUT and clears on exit.
//   - The timer never underflows. It is only loaded on state entry.
//   - unlock and locked_out are never high together. alarm is high only on the
//     first cycle of locked_out.
//   - Illegal state encoding -> ARMED with fail_cnt=0 (safe recovery).
// TESTING  (bench params: MAX_FAILS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16)
//   1 reset, pulse res_correct -> next cycle unlock=1, det_enable=0 for 8
//     cycles, then unlock=0, det_enable=1, fail_cnt=0
//   2 res_incorrect x2, then res_correct -> fail_cnt 1,2, then 0 with unlock=1
//     (counter clears on success)
//   3 res_incorrect x3 -> fail_cnt=3, alarm 1-cycle pulse, locked_out=1 for 16
//     cycles; res_correct pulses during lockout ignored; exit fail_cnt=0
//   4 res_correct and res_incorrect in same cycle while ARMED -> fail_cnt+1,
//     unlock stays 0
//   5 unlock, relock=1 at 3rd unlock cycle -> unlock=0 next cycle, state
//     ARMED; res_incorrect during UNLOCKED leaves fail_cnt unchanged
//   6 rstn low mid-LOCKOUT (cycle 5) -> all outputs at reset values
//     immediately; after release det_enable=1, fail_cnt=0

Source files
------------

// File: rtl/lock_attempt_ctrl.sv
// Door-unlock / failed-attempt lockout controller fed by the password detector's
// one-cycle result pulses; gates the detector off while unlocked or locked out.
module lock_attempt_ctrl #(
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 256,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             i_res_correct,
    input  logic                             i_res_incorrect,
    input  logic                             i_relock,
    output logic                             o_det_enable,
    output logic                             o_unlock,
    output logic                             o_locked_out,
    output logic                             o_alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0]   o_fail_cnt
);

    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [1:0] ST_ARMED    = 2'b00;
    localparam logic [1:0] ST_UNLOCKED = 2'b01;
    localparam logic [1:0] ST_LOCKOUT  = 2'b10;

    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
    localparam logic [TMR_W-1:0]  TMR_UNL   = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LOCK  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);

    logic [1:0]        r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [FAIL_W-1:0] r_fail_cnt;
    logic              r_det_enable;
    logic              r_unlock;
    logic              r_locked_out;
    logic              r_alarm;

    logic [1:0]        w_state_nxt;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic [FAIL_W-1:0] w_fail_nxt;
    logic              w_det_enable_nxt;
    logic              w_unlock_nxt;
    logic              w_locked_out_nxt;
    logic              w_alarm_nxt;

    // State, window timer and failure counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_ARMED;
            r_timer    <= TMR_ZERO;
            r_fail_cnt <= {FAIL_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_fail_cnt <= w_fail_nxt;
        end
    end

    // Next-state, timer and failure-count logic
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_fail_nxt  = r_fail_cnt;
        case (r_state)
            ST_ARMED: begin
                // A simultaneous correct+incorrect pair counts as a failure
                if (i_res_incorrect) begin
                    if (r_fail_cnt >= FAIL_LAST) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_timer_nxt = TMR_LOCK;
                        w_fail_nxt  = FAIL_MAX;
                    end else begin
                        w_fail_nxt  = r_fail_cnt + FAIL_W'(1);
                    end
                end else if (i_res_correct) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_timer_nxt = TMR_UNL;
                    w_fail_nxt  = {FAIL_W{1'b0}};
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_UNLOCKED: begin
                if (i_relock || (r_timer == TMR_ZERO)) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == TMR_ZERO) begin
                    w_state_nxt = ST_ARMED;
                    w_fail_nxt  = {FAIL_W{1'b0}};
                end else begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_ARMED;
                w_timer_nxt = TMR_ZERO;
                w_fail_nxt  = {FAIL_W{1'b0}};
            end
        endcase
    end

    // Output values decoded from the upcoming state so they register in step with it
    always_comb begin
        w_det_enable_nxt = 1'b0;
        w_unlock_nxt     = 1'b0;
        w_locked_out_nxt = 1'b0;
        w_alarm_nxt      = 1'b0;
        case (w_state_nxt)
            ST_ARMED:    w_det_enable_nxt = 1'b1;
            ST_UNLOCKED: w_unlock_nxt     = 1'b1;
            ST_LOCKOUT: begin
                w_locked_out_nxt = 1'b1;
                w_alarm_nxt      = (r_state == ST_ARMED);
            end
            default:     w_det_enable_nxt = 1'b1;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_det_enable <= 1'b1;
            r_unlock     <= 1'b0;
            r_locked_out <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_det_enable <= w_det_enable_nxt;
            r_unlock     <= w_unlock_nxt;
            r_locked_out <= w_locked_out_nxt;
            r_alarm      <= w_alarm_nxt;
        end
    end

    assign o_det_enable = r_det_enable;
    assign o_unlock     = r_unlock;
    assign o_locked_out = r_locked_out;
    assign o_alarm      = r_alarm;
    assign o_fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Directed self-checking bench for lock_attempt_ctrl (MAX_FAILS=3, UNLOCK=8, LOCKOUT=16).
module tb_lock_attempt_ctrl;

    logic       clk;
    logic       rstn;
    logic       i_res_correct;
    logic       i_res_incorrect;
    logic       i_relock;
    logic       o_det_enable;
    logic       o_unlock;
    logic       o_locked_out;
    logic       o_alarm;
    logic [1:0] o_fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    lock_attempt_ctrl #(
        .MAX_FAILS      (3),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_res_correct   (i_res_correct),
        .i_res_incorrect (i_res_incorrect),
        .i_relock        (i_relock),
        .o_det_enable    (o_det_enable),
        .o_unlock        (o_unlock),
        .o_locked_out    (o_locked_out),
        .o_alarm         (o_alarm),
        .o_fail_cnt      (o_fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic det, input logic unl,
                            input logic lo, input logic alm, input logic [1:0] fc);
        chk({tag, ".det_enable"}, {31'd0, o_det_enable}, {31'd0, det});
        chk({tag, ".unlock"},     {31'd0, o_unlock},     {31'd0, unl});
        chk({tag, ".locked_out"}, {31'd0, o_locked_out}, {31'd0, lo});
        chk({tag, ".alarm"},      {31'd0, o_alarm},      {31'd0, alm});
        chk({tag, ".fail_cnt"},   {30'd0, o_fail_cnt},   {30'd0, fc});
    endtask

    initial begin
        rstn            = 1'b0;
        i_res_correct   = 1'b0;
        i_res_incorrect = 1'b0;
        i_relock        = 1'b0;
        step();
        step();
        chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        rstn = 1'b1;
        step();
        chk_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 1: correct -> unlock for exactly 8 cycles
        i_res_correct = 1'b1;
        step();
        i_res_correct = 1'b0;
        chk_outs("t1.unl1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 2; i <= 8; i++) begin
            step();
            chk($sformatf("t1.unl%0d", i), {31'd0, o_unlock}, 32'd1);
        end
        step();
        chk_outs("t1.exit", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 2: two failures then success clears the count
        i_res_incorrect = 1'b1;
        step();
        chk_outs("t2.f1", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        step();
        i_res_incorrect = 1'b0;
        chk_outs("t2.f2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        i_res_correct = 1'b1;
        step();
        i_res_correct = 1'b0;
        chk_outs("t2.ok", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 8; i++) step();
        chk_outs("t2.exit", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 3: three failures -> alarm + 16-cycle lockout, correct pulses ignored
        i_res_incorrect = 1'b1;
        step();
        chk("t3.f1", {30'd0, o_fail_cnt}, 32'd1);
        step();
        chk("t3.f2", {30'd0, o_fail_cnt}, 32'd2);
        step();
        i_res_incorrect = 1'b0;
        chk_outs("t3.lock1", 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
        for (int i = 2; i <= 16; i++) begin
            i_res_correct = (i % 2 == 0);
            step();
            i_res_correct = 1'b0;
            chk_outs($sformatf("t3.lock%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        end
        step();
        chk_outs("t3.exit", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 4: both pulses together count as a failure
        i_res_correct   = 1'b1;
        i_res_incorrect = 1'b1;
        step();
        i_res_correct   = 1'b0;
        i_res_incorrect = 1'b0;
        chk_outs("t4.both", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

        // 5: unlock, failure ignored while unlocked, relock on 3rd cycle
        i_res_correct = 1'b1;
        step();
        i_res_correct   = 1'b0;
        i_res_incorrect = 1'b1;
        chk_outs("t5.unl1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        step();
        i_res_incorrect = 1'b0;
        chk_outs("t5.unl2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        step();
        chk_outs("t5.unl3", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        i_relock = 1'b1;
        step();
        i_relock = 1'b0;
        chk_outs("t5.relock", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 6: async reset in the middle of lockout
        i_res_incorrect = 1'b1;
        step();
        step();
        step();
        i_res_incorrect = 1'b0;
        chk_outs("t6.lock1", 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++) step();
        chk("t6.lock5", {31'd0, o_locked_out}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk_outs("t6.rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step();
        rstn = 1'b1;
        step();
        step();
        chk_outs("t6.after", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
